// File: rtl/mash_div_ctrl.sv
// Fractional-N divide controller: counts n_int + y cycles per period, pulses div_o at the
// end of each period and strobes the MASH modulator to advance on every load.
module mash_div_ctrl #(
  parameter int unsigned NW      = 8,
  parameter int unsigned MIN_DIV = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  input  logic [NW-1:0] n_int_i,
  input  logic [3:0]    y_i,
  input  logic          clr_i,
  output logic          div_o,
  output logic          mash_ce_o,
  output logic [NW:0]   ratio_o,
  output logic          clamp_o
);

  typedef enum logic {StIdle, StRun} state_e;

  localparam logic signed [NW+1:0] MinDivS = $signed((NW+2)'(MIN_DIV));
  localparam logic [NW:0]          MinDivU = (NW+1)'(MIN_DIV);

  state_e             state_q, state_d;
  logic [NW:0]        cnt_q, cnt_d;
  logic [NW:0]        ratio_q, ratio_d;
  logic               clamp_q, clamp_d;
  logic signed [NW+1:0] d_raw;
  logic [NW:0]        d_val;
  logic               below_min;
  logic               term;
  logic               load;

  // Two guard bits: one for the sign of y, one so n_int + 7 cannot overflow.
  assign d_raw     = $signed({2'b00, n_int_i}) + $signed({{(NW-2){y_i[3]}}, y_i});
  assign below_min = d_raw < MinDivS;
  assign d_val     = below_min ? MinDivU : d_raw[NW:0];

  assign term = (state_q == StRun) && (cnt_q == '0);
  assign load = en_i && ((state_q == StIdle) || term);

  assign div_o     = term;
  // Gated by rst_n so the strobe is silent while reset holds the counter.
  assign mash_ce_o = load && rst_n;
  assign ratio_o   = ratio_q;
  assign clamp_o   = clamp_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ratio_d = ratio_q;
    clamp_d = clamp_q;
    if (load) begin
      state_d = StRun;
      cnt_d   = d_val - (NW+1)'(1);
      ratio_d = d_val;
    end else if (state_q == StRun) begin
      if (term) begin
        state_d = StIdle;
      end else begin
        cnt_d = cnt_q - (NW+1)'(1);
      end
    end
    if (clr_i) begin
      clamp_d = 1'b0;
    end
    if (load && below_min) begin
      clamp_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ratio_q <= '0;
      clamp_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ratio_q <= ratio_d;
      clamp_q <= clamp_d;
    end
  end

endmodule

// File: tb/tb_mash_div_ctrl.sv
// Scoreboard bench for mash_div_ctrl: stimulus queues expected pulses and levels,
// a negedge monitor pops and compares them.
module tb_mash_div_ctrl;

  localparam int NW = 8;

  localparam int SigClamp  = 0;
  localparam int SigRatio  = 1;
  localparam int SigDiv    = 2;
  localparam int SigCe     = 3;
  localparam int SigDiv2   = 4;
  localparam int SigCe2    = 5;
  localparam int SigRatio2 = 6;
  localparam int SigClamp2 = 7;

  typedef struct {
    int cyc;
    int sig;
    int val;
  } lvl_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          en_i = 1'b0;
  logic [NW-1:0] n_int_i = '0;
  logic [3:0]    y_i = '0;
  logic          clr_i = 1'b0;
  logic          div_o, mash_ce_o, clamp_o;
  logic [NW:0]   ratio_o;

  logic          en2 = 1'b0;
  logic [NW-1:0] n2 = '0;
  logic [3:0]    y2 = '0;
  logic          div2, ce2, clamp2;
  logic [NW:0]   ratio2;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_fail = 0;
  bit   done = 1'b0;
  int   ce_q[$];
  int   div_cyc_q[$];
  int   div_ratio_q[$];
  lvl_t lvl_q[$];

  mash_div_ctrl #(.NW(NW), .MIN_DIV(2)) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .n_int_i(n_int_i), .y_i(y_i), .clr_i(clr_i),
    .div_o(div_o), .mash_ce_o(mash_ce_o), .ratio_o(ratio_o), .clamp_o(clamp_o)
  );

  mash_div_ctrl #(.NW(NW), .MIN_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en_i(en2), .n_int_i(n2), .y_i(y2), .clr_i(1'b0),
    .div_o(div2), .mash_ce_o(ce2), .ratio_o(ratio2), .clamp_o(clamp2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int sig_val(input int sig);
    case (sig)
      SigClamp:  return int'(clamp_o);
      SigRatio:  return int'(ratio_o);
      SigDiv:    return int'(div_o);
      SigCe:     return int'(mash_ce_o);
      SigDiv2:   return int'(div2);
      SigCe2:    return int'(ce2);
      SigRatio2: return int'(ratio2);
      default:   return int'(clamp2);
    endcase
  endfunction

  // Monitor: owns every comparison and the summary.
  always @(negedge clk) begin
    while (lvl_q.size() > 0 && lvl_q[0].cyc <= cyc) begin
      lvl_t e;
      e = lvl_q.pop_front();
      n_vec++;
      if (e.cyc != cyc || sig_val(e.sig) != e.val) begin
        n_fail++;
        $display("FAIL level sig%0d cyc %0d: got %0d want %0d (checked at cyc %0d)",
                 e.sig, e.cyc, sig_val(e.sig), e.val, cyc);
      end
    end
    if (div_cyc_q.size() > 0 && div_cyc_q[0] < cyc) begin
      n_vec++;
      n_fail++;
      $display("FAIL div missing: want pulse at cyc %0d, none by cyc %0d", div_cyc_q[0], cyc);
      void'(div_cyc_q.pop_front());
      void'(div_ratio_q.pop_front());
    end
    if (ce_q.size() > 0 && ce_q[0] < cyc) begin
      n_vec++;
      n_fail++;
      $display("FAIL ce missing: want strobe at cyc %0d, none by cyc %0d", ce_q[0], cyc);
      void'(ce_q.pop_front());
    end
    if (div_o) begin
      n_vec++;
      if (div_cyc_q.size() == 0) begin
        n_fail++;
        $display("FAIL div unexpected: got pulse at cyc %0d, want none", cyc);
      end else begin
        int wc, wr;
        wc = div_cyc_q.pop_front();
        wr = div_ratio_q.pop_front();
        if (wc != cyc || int'(ratio_o) != wr) begin
          n_fail++;
          $display("FAIL div pulse: got cyc %0d ratio %0d want cyc %0d ratio %0d",
                   cyc, ratio_o, wc, wr);
        end
      end
    end
    if (mash_ce_o) begin
      n_vec++;
      if (ce_q.size() == 0) begin
        n_fail++;
        $display("FAIL ce unexpected: got strobe at cyc %0d, want none", cyc);
      end else begin
        int wc;
        wc = ce_q.pop_front();
        if (wc != cyc) begin
          n_fail++;
          $display("FAIL ce strobe: got cyc %0d want cyc %0d", cyc, wc);
        end
      end
    end
    if (done) begin
      n_vec = n_vec + lvl_q.size() + div_cyc_q.size() + ce_q.size();
      n_fail = n_fail + lvl_q.size() + div_cyc_q.size() + ce_q.size();
      if (lvl_q.size() + div_cyc_q.size() + ce_q.size() != 0) begin
        $display("FAIL leftover: got %0d unmatched expectations want 0",
                 lvl_q.size() + div_cyc_q.size() + ce_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
    end
  end

  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_lvl(input int sig, input int val);
    lvl_t e;
    e.cyc = cyc;
    e.sig = sig;
    e.val = val;
    lvl_q.push_back(e);
  endtask

  // Load at the current cycle; returns at the terminal cycle of this period.
  task automatic period(input int n, input int y, input int d, input bit clr);
    ce_q.push_back(cyc);
    div_cyc_q.push_back(cyc + d);
    div_ratio_q.push_back(d);
    n_int_i = NW'(n);
    y_i     = 4'(y);
    clr_i   = clr;
    en_i    = 1'b1;
    tick(1);
    clr_i = 1'b0;
    expect_lvl(SigRatio, d);
    if (d > 1) begin
      n_int_i = NW'($urandom);
      y_i     = 4'($urandom);
      tick(d - 1);
    end
  endtask

  task automatic stop();
    en_i = 1'b0;
    tick(1);
    expect_lvl(SigDiv, 0);
    expect_lvl(SigCe, 0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    en_i = 1'b1;
    tick(1);
    expect_lvl(SigDiv, 0);
    expect_lvl(SigCe, 0);
    expect_lvl(SigRatio, 0);
    expect_lvl(SigClamp, 0);
    en_i = 1'b0;
    rst_n = 1'b1;
    tick(2);

    // Steady integer divide
    repeat (3) period(10, 0, 10, 1'b0);
    expect_lvl(SigClamp, 0);
    // y sequence +4,-3,+1,0
    period(10, 4, 14, 1'b0);
    period(10, -3, 7, 1'b0);
    period(10, 1, 11, 1'b0);
    period(10, 0, 10, 1'b0);
    stop();
    tick(2);

    // Clamp, clear, and set-beats-clear
    period(3, -3, 2, 1'b0);
    expect_lvl(SigClamp, 1);
    period(3, 0, 3, 1'b1);
    expect_lvl(SigClamp, 0);
    period(3, -3, 2, 1'b1);
    expect_lvl(SigClamp, 1);
    stop();
    tick(1);

    // en_i dropped 3 cycles into a 10-cycle period
    ce_q.push_back(cyc);
    div_cyc_q.push_back(cyc + 10);
    div_ratio_q.push_back(10);
    n_int_i = 8'd10;
    y_i = 4'd0;
    en_i = 1'b1;
    tick(3);
    en_i = 1'b0;
    tick(7);
    tick(1);
    expect_lvl(SigDiv, 0);
    tick(2);
    expect_lvl(SigRatio, 10);
    period(10, 2, 12, 1'b0);
    period(4, 0, 4, 1'b0);

    // Async reset mid-period, then restart
    ce_q.push_back(cyc);
    n_int_i = 8'd10;
    y_i = 4'd0;
    en_i = 1'b1;
    tick(4);
    #2 rst_n = 1'b0;
    expect_lvl(SigDiv, 0);
    expect_lvl(SigCe, 0);
    expect_lvl(SigRatio, 0);
    expect_lvl(SigClamp, 0);
    tick(1);
    en_i = 1'b0;
    rst_n = 1'b1;
    tick(1);
    period(10, 0, 10, 1'b0);
    period(5, 1, 6, 1'b0);
    stop();
    tick(2);

    // MIN_DIV=1 instance: ratio 1 pulses every cycle
    en2 = 1'b1;
    n2 = 8'd1;
    y2 = 4'd0;
    expect_lvl(SigCe2, 1);
    expect_lvl(SigDiv2, 0);
    tick(1);
    repeat (5) begin
      expect_lvl(SigDiv2, 1);
      expect_lvl(SigCe2, 1);
      expect_lvl(SigRatio2, 1);
      tick(1);
    end
    expect_lvl(SigClamp2, 0);
    y2 = 4'hF;
    tick(1);
    expect_lvl(SigClamp2, 1);
    expect_lvl(SigDiv2, 1);
    expect_lvl(SigRatio2, 1);
    en2 = 1'b0;
    tick(2);

    done = 1'b1;
    tick(3);
    $display("FAIL monitor: got no summary, want summary after done");
    $fatal(1);
  end

endmodule
